// File: rtl/ngc_counter_sched_pkg.sv
// Shared types for the ngc_counter scheduler and its round-robin arbiter.
package ngc_counter_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FINISH,
    CLEAR
  } state_t;

  // The counter belongs to a job in every state except IDLE.
  function automatic logic owns_counter(input state_t s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/ngc_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first valid index
// at or after pointer, wrapping modulo N; zero when disabled or nothing valid.
module ngc_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] pointer,
  input  logic          enable,
  output logic [N-1:0]  grant
);

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(pointer) + i) % N);
      if (enable && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ngc_counter_sched.sv
// Round-robin scheduler time-sharing one ngc_counter among N_REQ requesters.
// Optional watchdog enabled by NGC_COUNTER_SCHED_TIMEOUT_EN (parameter TMO_CYCLES).
module ngc_counter_sched
  import ngc_counter_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N_REQ = 4
`ifdef NGC_COUNTER_SCHED_TIMEOUT_EN
  ,
  parameter int unsigned TMO_CYCLES = 1024
`endif
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ-1:0][WIDTH-1:0]      req_from,
  input  logic [N_REQ-1:0][WIDTH-1:0]      req_to,
  input  logic [N_REQ-1:0][WIDTH/2-1:0]    req_step,
  input  logic [N_REQ-1:0]                 req_dir,
  input  logic [N_REQ-1:0]                 req_cancel,
  output logic [N_REQ-1:0]                 done,
  output logic [N_REQ-1:0]                 err,
  output logic                             busy,
  output logic                             cnt_rst,
  output logic                             cnt_load,
  output logic                             cnt_enb,
  output logic                             cnt_dir,
  output logic                             cnt_one_shot,
  output logic [WIDTH-1:0]                 cnt_load_value,
  output logic [WIDTH-1:0]                 cnt_count_from_value,
  output logic [WIDTH-1:0]                 cnt_count_to_value,
  output logic [WIDTH/2-1:0]               cnt_step_value,
  input  logic [WIDTH-1:0]                 cnt_count,
  input  logic                             cnt_count_hit
);

  localparam int unsigned SW = WIDTH / 2;
  localparam int unsigned PW = $clog2(N_REQ);

  typedef struct packed {
    logic [WIDTH-1:0] from;
    logic [WIDTH-1:0] to;
    logic [SW-1:0]    step;
    logic             dir;
  } job_t;

  state_t           state_q, state_d;
  job_t             job_q, job_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] done_q, done_d, err_q, err_d;
  logic             busy_d, cnt_rst_d, cnt_load_d, cnt_enb_d;
  logic [PW-1:0]    grant_idx;
  logic             arb_en, reject, tmo;

  // The counter value is for monitoring only.
  logic unused_cnt_count;
  assign unused_cnt_count = ^cnt_count;

  assign arb_en = (state_q == IDLE);

  ngc_rr_arbiter #(.N(N_REQ)) u_arb (
    .valid   (req_valid),
    .pointer (ptr_q),
    .enable  (arb_en),
    .grant   (req_ready)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_ready[PW'(i)]) grant_idx = PW'(i);
    end
  end

  assign reject = (req_step[grant_idx] == '0) ||
                  (req_dir[grant_idx] ? (req_to[grant_idx] < req_from[grant_idx])
                                      : (req_to[grant_idx] > req_from[grant_idx]));

`ifdef NGC_COUNTER_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO_CYCLES + 1);
  logic [TW-1:0] wd_q, wd_d;

  assign tmo = (wd_q == TW'(TMO_CYCLES - 1));

  // Watchdog restarts on every RUN entry and only counts while running.
  always_comb begin
    wd_d = wd_q;
    if (state_q == LOAD)     wd_d = '0;
    else if (state_q == RUN) wd_d = wd_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  assign tmo = 1'b0;
`endif

  // Next state plus the registered output values for the coming cycle.
  always_comb begin
    state_d = state_q;
    job_d   = job_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    done_d  = '0;
    err_d   = '0;
    case (state_q)
      IDLE: begin
        if (|req_ready) begin
          job_d   = '{from: req_from[grant_idx], to: req_to[grant_idx],
                      step: req_step[grant_idx], dir: req_dir[grant_idx]};
          owner_d = grant_idx;
          ptr_d   = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);
          if (reject) err_d[grant_idx] = 1'b1;
          else        state_d = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        // A same-cycle hit beats both cancel and timeout.
        if (cnt_count_hit) begin
          state_d         = FINISH;
          done_d[owner_q] = 1'b1;
        end else if (req_cancel[owner_q] || tmo) begin
          state_d        = CLEAR;
          err_d[owner_q] = 1'b1;
        end
      end
      FINISH:  state_d = CLEAR;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d     = owns_counter(state_d);
    cnt_rst_d  = (state_d == IDLE) || (state_d == CLEAR);
    cnt_load_d = (state_d == LOAD);
    cnt_enb_d  = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      job_q    <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      busy     <= 1'b0;
      cnt_rst  <= 1'b1;
      cnt_load <= 1'b0;
      cnt_enb  <= 1'b0;
    end else begin
      state_q  <= state_d;
      job_q    <= job_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy     <= busy_d;
      cnt_rst  <= cnt_rst_d;
      cnt_load <= cnt_load_d;
      cnt_enb  <= cnt_enb_d;
    end
  end

  assign done                 = done_q;
  assign err                  = err_q;
  assign cnt_one_shot         = 1'b1;
  assign cnt_dir              = job_q.dir;
  assign cnt_load_value       = job_q.from;
  assign cnt_count_from_value = job_q.from;
  assign cnt_count_to_value   = job_q.to;
  assign cnt_step_value       = job_q.step;

endmodule

// File: doc/ngc_counter_sched.md
Name: ngc_counter_sched

Overview:
Scheduler that time-shares one ngc_counter instance among N_REQ requesters. Each requester submits an interval job (from, to, step, dir) over a valid/ready handshake. The block grants requests round-robin, configures and runs the counter in one-shot mode, and returns a per-requester done or error pulse. It sits between the requesting agents and the counter's master-side signals.

Parameters:
WIDTH, 16, counter width; must match the attached ngc_counter; even, >= 4
N_REQ, 4, number of requesters; 2..16

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester job valid
req_ready  out  N_REQ  per-requester accept; one-hot or zero
req_from  in  N_REQ x WIDTH  start value per requester
req_to  in  N_REQ x WIDTH  terminal value per requester
req_step  in  N_REQ x WIDTH/2  step per requester
req_dir  in  N_REQ  1 = count up, 0 = count down
req_cancel  in  N_REQ  abort the running job of that requester
done  out  N_REQ  one-cycle pulse: job reached terminal value
err  out  N_REQ  one-cycle pulse: job rejected or cancelled
busy  out  1  counter owned by a job
cnt_rst  out  1  counter reset, active-high
cnt_load, cnt_enb, cnt_dir, cnt_one_shot  out  1 each  counter controls
cnt_load_value, cnt_count_from_value, cnt_count_to_value  out  WIDTH  counter config
cnt_step_value  out  WIDTH/2  counter step
cnt_count  in  WIDTH  counter value (monitor only)
cnt_count_hit  in  1  counter reached count_to

Behaviour:
- Reset (async assert, sync release): state IDLE, rr pointer 0. All outputs 0 except cnt_rst=1 and cnt_one_shot=1. Config registers are 0.
- States: IDLE, LOAD, RUN, FINISH, CLEAR.
- IDLE:
  - req_ready is combinational. It is one-hot on the first valid index at or after the rr pointer, wrapping modulo N_REQ, and 0 if no request is valid.
  - A handshake (valid && ready) captures from/to/step/dir and the owner index.
  - The rr pointer moves to owner+1 mod N_REQ.
  - Validation at acceptance: reject if step==0, if dir=1 and to<from, or if dir=0 and to>from. A rejected job pulses err[owner] the next cycle and stays in IDLE.
  - from==to is legal and completes via count_hit.
  - Otherwise go to LOAD.
- LOAD (1 cycle):
  - cnt_rst=0, cnt_load=1, cnt_enb=0.
  - cnt_load_value = cnt_count_from_value = from.
  - Drive to, step and dir; cnt_one_shot=1.
  - Next state RUN.
- RUN:
  - cnt_enb=1, busy=1.
  - Config outputs held stable for the whole job.
  - cnt_count_hit sampled high -> FINISH.
  - req_cancel[owner] high -> CLEAR, with err[owner] pulsed in the CLEAR cycle.
  - If hit and cancel occur in the same cycle, hit wins.
- FINISH (1 cycle): done[owner]=1, cnt_enb=0 -> CLEAR.
- CLEAR (1 cycle): cnt_rst=1, cnt_enb=0 -> IDLE. req_ready stays 0 until IDLE.
- busy=1 in LOAD, RUN, FINISH and CLEAR.
- Latency: handshake in cycle T; LOAD at T+1; first enabled count at T+2; done one cycle after hit is sampled; next acceptance 2 cycles after done.
- req_cancel for a non-owner, or while not in RUN, is ignored.
- Queued (non-granted) requests hold until granted; req_valid withdrawal before ready is allowed.
- rst_n asserted mid-job aborts immediately to the reset values; no done or err is issued.

Optional Feature:
NGC_COUNTER_SCHED_TIMEOUT_EN:
- Defined: adds parameter TMO_CYCLES (default 1024) and a watchdog counter cleared on entry to RUN. If count_hit is not seen within TMO_CYCLES cycles, the block goes to CLEAR and pulses err[owner]. A same-cycle hit beats the timeout.
- Undefined: no watchdog; RUN waits indefinitely.

Decomposition:
- ngc_counter_sched_pkg: state_t enum (IDLE, LOAD, RUN, FINISH, CLEAR) and a job_t struct {from, to, step, dir}. job_t is parameterised via WIDTH-sized localparams in the module, or via typedef inside a parameterised class, per team practice.
- Sub-module ngc_rr_arbiter #(N): inputs valid, pointer, enable; output one-hot grant. Purely combinational, reusable.

Test Plan:
- Single job: req0 from=0, to=10, step=2, up -> ready0 at T; cnt_load at T+1 with load_value=0; done[0] one cycle after cnt_count_hit; no err.
- Round-robin: req0..3 all valid continuously, each with from=5, to=5 -> grants in order 0,1,2,3,0; each done pulses exactly once per grant.
- Rejection: req2 with step=0 -> err[2] next cycle, no cnt_load; req1 up with from=20, to=10 -> err[1].
- Cancel vs hit: req_cancel[owner] in the same cycle as cnt_count_hit -> done only. Cancel alone in RUN -> err, cnt_rst pulse, IDLE. Cancel from a non-owner -> ignored.
- Reset mid-RUN: drop rst_n while cnt_enb=1 -> cnt_rst=1 and cnt_enb=0 immediately, no done/err; the next request is granted from index 0.
- With NGC_COUNTER_SCHED_TIMEOUT_EN, TMO_CYCLES=8: hold cnt_count_hit low -> err[owner] 8 cycles after RUN entry, then IDLE.
